rainbow_walk_ctrl: RTL and testbench

//   Sequencer for the RGB444 hue walk used by the OLED colour effects.
//   - Owns the 6-phase ramp state and paces it with a programmable prescaler.
//   - Provides start, pause, stop and single-step control, plus walk direction.
//   - Delivers one frame-synchronous colour snapshot per frame_start over a valid/ready handshake.

---
 rtl/rainbow_walk_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rainbow_walk_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rainbow_walk_ctrl.sv
// rtl/rainbow_walk_ctrl.sv - six-phase RGB hue walk sequencer with frame-synchronous snapshot handshake.
// Define RAINBOW_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module rainbow_walk_ctrl #(
  parameter int CH_W  = 4,
  parameter int DIV_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              step_req,
  input  logic              dir,
  input  logic [DIV_W-1:0]  rate,
  input  logic              frame_start,
  output logic [3*CH_W-1:0] color,
  output logic              color_valid,
  input  logic              color_ready,
  output logic              busy,
  output logic [2:0]        phase
`ifdef RAINBOW_OVERRUN_CNT_EN
  ,
  output logic [7:0]        overrun_cnt
`endif
);

  localparam logic [CH_W-1:0]  MAX     = {CH_W{1'b1}};
  localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  typedef struct packed {
    logic [2:0]      ph;
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } hue_t;

  localparam hue_t HUE_RST = {3'd0, MAX, {CH_W{1'b0}}, {CH_W{1'b0}}};

  state_t           state;
  hue_t             hue;
  hue_t             hue_nx;
  logic [DIV_W-1:0] cnt;
  logic             tick;
  logic             do_step;
  logic             go_idle;
  logic             overrun;

  function automatic logic [2:0] ph_inc(input logic [2:0] p);
    return (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [2:0] ph_dec(input logic [2:0] p);
    return (p == 3'd0) ? 3'd5 : p - 3'd1;
  endfunction

  function automatic logic [CH_W-1:0] chan_of(input hue_t h, input logic [2:0] p);
    logic [CH_W-1:0] v;
    case (p)
      3'd1, 3'd4: v = h.r;
      3'd2, 3'd5: v = h.b;
      default:    v = h.g;
    endcase
    return v;
  endfunction

  // If the active channel already sits at the value this direction heads for
  // (boundary state, or just after a dir flip), the step belongs to the neighbouring phase.
  function automatic hue_t hue_step(input hue_t h, input logic rev);
    hue_t            n;
    logic [2:0]      e;
    logic            rise;
    logic [CH_W-1:0] tgt;
    logic [CH_W-1:0] v;
    n    = h;
    e    = h.ph;
    rise = ~e[0] ^ rev;
    tgt  = rise ? MAX : '0;
    if (chan_of(h, e) == tgt) begin
      e    = rev ? ph_dec(e) : ph_inc(e);
      rise = ~e[0] ^ rev;
      tgt  = rise ? MAX : '0;
    end
    v    = rise ? chan_of(h, e) + CH_ONE : chan_of(h, e) - CH_ONE;
    n.ph = (v == tgt) ? (rev ? ph_dec(e) : ph_inc(e)) : e;
    case (e)
      3'd1, 3'd4: n.r = v;
      3'd2, 3'd5: n.b = v;
      default:    n.g = v;
    endcase
    return n;
  endfunction

  always_comb begin
    tick    = (state == RUN) && (cnt >= rate);
    go_idle = (state == PAUSE) && stop && !start;
    do_step = (state == RUN) ? (tick && !stop) : (step_req && !start && !stop);
    overrun = frame_start && color_valid && !color_ready;
    hue_nx  = hue;
    if (go_idle)
      hue_nx = HUE_RST;
    else if (do_step)
      hue_nx = hue_step(hue, dir);
  end

  assign phase = hue.ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      hue         <= HUE_RST;
      cnt         <= '0;
      color       <= '0;
      color_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= PAUSE;
            busy  <= 1'b0;
          end
        end
        PAUSE: begin
          // start and stop together cancel each other: remain paused
          if (go_idle) begin
            state <= IDLE;
          end else if (start && !stop) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      cnt <= (state == RUN && !stop && !tick) ? cnt + DIV_ONE : '0;
      hue <= hue_nx;

      if (frame_start) begin
        color       <= {hue_nx.r, hue_nx.g, hue_nx.b};
        color_valid <= 1'b1;
      end else if (color_valid && color_ready) begin
        color_valid <= 1'b0;
      end
    end
  end

`ifdef RAINBOW_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun_cnt <= 8'd0;
    else if (go_idle)
      overrun_cnt <= 8'd0;
    else if (overrun && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_rainbow_walk_ctrl.sv
// tb/tb_rainbow_walk_ctrl.sv - directed self-checking bench for rainbow_walk_ctrl.
module tb_rainbow_walk_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        step_req;
  logic        dir;
  logic [19:0] rate;
  logic        frame_start;
  logic [11:0] color;
  logic        color_valid;
  logic        color_ready;
  logic        busy;
  logic [2:0]  phase;
`ifdef RAINBOW_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  rainbow_walk_ctrl #(.CH_W(4), .DIV_W(20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .step_req    (step_req),
    .dir         (dir),
    .rate        (rate),
    .frame_start (frame_start),
    .color       (color),
    .color_valid (color_valid),
    .color_ready (color_ready),
    .busy        (busy),
    .phase       (phase)
`ifdef RAINBOW_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int g2[16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 4, 4, 5};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step_req = 1'b0; dir = 1'b0;
    rate = 20'd0; frame_start = 1'b0; color_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_color", 32'(color), 32'h000);
    check("rst_valid", 32'(color_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    rst_n = 1'b1;
    cyc();

    // full forward walk at rate 0
    start = 1'b1; cyc(); start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    repeat (14) cyc();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    check("t1_color15", 32'(color), 32'hFF0);
    check("t1_phase15", 32'(phase), 32'd1);
    check("t1_valid", 32'(color_valid), 32'd1);
    cyc();
    check("t1_valid_drop", 32'(color_valid), 32'd0);
    repeat (73) cyc();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    check("t1_color90", 32'(color), 32'hF00);
    check("t1_phase90", 32'(phase), 32'd0);
    stop = 1'b1; cyc(); cyc(); stop = 1'b0;
    check("t1_idle_busy", 32'(busy), 32'd0);

    // prescaler pacing and live rate change
    rate = 20'd3; frame_start = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 12) rate = 20'd1;
      cyc();
      check($sformatf("t2_g_e%0d", k), 32'(color), 32'hF00 | (32'(g2[k-1]) << 4));
    end
    frame_start = 1'b0; rate = 20'd0;
    stop = 1'b1; cyc(); cyc(); stop = 1'b0;

    // stop, single-step, return to idle, start+stop from pause
    start = 1'b1; cyc(); start = 1'b0;
    repeat (7) cyc();
    stop = 1'b1; frame_start = 1'b1; cyc(); stop = 1'b0; frame_start = 1'b0;
    check("t3_frozen", 32'(color), 32'hF70);
    check("t3_pause_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step_req = 1'b1; cyc(); step_req = 1'b0; cyc();
    end
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    check("t3_steps", 32'(color), 32'hFA0);
    check("t3_steps_busy", 32'(busy), 32'd0);
    stop = 1'b1; frame_start = 1'b1; cyc(); stop = 1'b0; frame_start = 1'b0;
    check("t3_idle_hue", 32'(color), 32'hF00);
    check("t3_idle_phase", 32'(phase), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    check("t3_rerun_busy", 32'(busy), 32'd1);
    stop = 1'b1; cyc(); stop = 1'b0;
    check("t3_repause_busy", 32'(busy), 32'd0);
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    check("t3_both_busy", 32'(busy), 32'd0);
    step_req = 1'b1; frame_start = 1'b1; cyc(); step_req = 1'b0; frame_start = 1'b0;
    check("t3_both_step", 32'(color), 32'hF10);
    stop = 1'b1; frame_start = 1'b1; cyc(); stop = 1'b0; frame_start = 1'b0;
    check("t3_both_was_pause", 32'(color), 32'hF00);

    // reverse walk and mid-phase direction flips
    dir = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    frame_start = 1'b1; cyc();
    check("t4_first", 32'(color), 32'hF01);
    check("t4_first_ph", 32'(phase), 32'd5);
    repeat (14) cyc();
    check("t4_f0f", 32'(color), 32'hF0F);
    check("t4_f0f_ph", 32'(phase), 32'd4);
    repeat (3) cyc();
    check("t4_c0f", 32'(color), 32'hC0F);
    dir = 1'b0; cyc();
    check("t4_fwd1", 32'(color), 32'hD0F);
    cyc();
    check("t4_fwd2", 32'(color), 32'hE0F);
    dir = 1'b1; cyc();
    check("t4_rev", 32'(color), 32'hD0F);
    check("t4_rev_ph", 32'(phase), 32'd4);
    frame_start = 1'b0; dir = 1'b0;
    stop = 1'b1; cyc(); cyc(); stop = 1'b0;

    // snapshot handshake and overrun
    color_ready = 1'b0;
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    check("t5_valid", 32'(color_valid), 32'd1);
    check("t5_snap1", 32'(color), 32'hF00);
    step_req = 1'b1; cyc(); step_req = 1'b0;
    check("t5_stable", 32'(color), 32'hF00);
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    check("t5_snap2", 32'(color), 32'hF10);
    check("t5_valid_ovr", 32'(color_valid), 32'd1);
`ifdef RAINBOW_OVERRUN_CNT_EN
    check("t5_ovr_cnt", 32'(overrun_cnt), 32'd1);
`endif
    cyc();
    check("t5_valid_hold", 32'(color_valid), 32'd1);
    color_ready = 1'b1; cyc();
    check("t5_valid_drop", 32'(color_valid), 32'd0);
    frame_start = 1'b1; cyc(); cyc(); frame_start = 1'b0;
    check("t5_accept_reload", 32'(color_valid), 32'd1);
    cyc();
    check("t5_valid_drop2", 32'(color_valid), 32'd0);
`ifdef RAINBOW_OVERRUN_CNT_EN
    check("t5_ovr_keep", 32'(overrun_cnt), 32'd1);
    start = 1'b1; cyc(); start = 1'b0;
    stop = 1'b1; cyc(); cyc(); stop = 1'b0;
    check("t5_ovr_clear", 32'(overrun_cnt), 32'd0);
`else
    start = 1'b1; cyc(); start = 1'b0;
    stop = 1'b1; cyc(); cyc(); stop = 1'b0;
`endif

    // asynchronous reset mid-ramp
    color_ready = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    repeat (19) cyc();
    check("t6_pre_phase", 32'(phase), 32'd1);
    check("t6_pre_valid", 32'(color_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_color", 32'(color), 32'h000);
    check("t6_valid", 32'(color_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_phase", 32'(phase), 32'd0);
    rst_n = 1'b1;
    cyc();
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    check("t6_hue_rst", 32'(color), 32'hF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
